// File: rtl/hdmi_word_align.sv
// HDMI TMDS word alignment controller.
// Steps the downstream slip stage until control tokens arrive back-to-back,
// then watches for their continued presence and drops lock when they vanish.
module hdmi_word_align #(
    parameter int LGWINDOW = 20,
    parameter int RUNLEN   = 8,
    parameter int SETTLE   = 4,
    parameter int MISSLIM  = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [9:0] i_pixel,
    output logic [4:0] o_slip,
    output logic       o_locked,
    output logic       o_lost
);

    localparam int RUNW = $clog2(RUNLEN + 1);
    localparam logic [RUNW-1:0]     RUN_MAX     = RUNW'(RUNLEN);
    localparam logic [RUNW-1:0]     RUN_ONE     = RUNW'(1);
    localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0]          MISS_MAX    = 4'(MISSLIM);
    localparam logic [LGWINDOW-1:0] WIN_MAX     = '1;
    localparam logic [LGWINDOW-1:0] WIN_ONE     = LGWINDOW'(1);

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_SEARCH,
        ST_LOCKED
    } state_t;

    state_t              state, state_next;
    logic [LGWINDOW-1:0] win_cnt, win_next;
    logic [RUNW-1:0]     run_cnt, run_next, run_step;
    logic [3:0]          miss_cnt, miss_next, miss_inc;
    logic [3:0]          settle_cnt, settle_next;
    logic                seen_run, seen_next;
    logic [4:0]          slip_next, slip_inc;
    logic                locked_next, lost_next;
    logic                is_token, run_hit, win_end;

    // Token decode, saturating run step and wrap-around slip increment.
    always_comb begin
        is_token = (i_pixel == 10'h354) || (i_pixel == 10'h0ab) ||
                   (i_pixel == 10'h154) || (i_pixel == 10'h2ab);
        if (!is_token)
            run_step = '0;
        else if (run_cnt == RUN_MAX)
            run_step = run_cnt;
        else
            run_step = run_cnt + RUN_ONE;
        run_hit  = (run_step == RUN_MAX);
        win_end  = (win_cnt == WIN_MAX);
        miss_inc = miss_cnt + 4'd1;
        slip_inc = (o_slip == 5'd9) ? 5'd0 : o_slip + 5'd1;
    end

    // Next-state and next-output logic for the settle/search/locked loop.
    always_comb begin
        state_next  = state;
        win_next    = win_cnt;
        run_next    = run_cnt;
        miss_next   = miss_cnt;
        settle_next = settle_cnt;
        seen_next   = seen_run;
        slip_next   = o_slip;
        locked_next = 1'b0;
        lost_next   = 1'b0;
        case (state)
            ST_SETTLE: begin
                run_next = '0;
                if (settle_cnt == SETTLE_LAST) begin
                    state_next  = ST_SEARCH;
                    settle_next = '0;
                    win_next    = '0;
                end else begin
                    settle_next = settle_cnt + 4'd1;
                end
            end
            ST_SEARCH: begin
                run_next = run_step;
                win_next = win_cnt + WIN_ONE;
                if (run_hit) begin
                    // A completed run wins over a window expiring on the same clock.
                    state_next = ST_LOCKED;
                    win_next   = '0;
                    miss_next  = '0;
                    seen_next  = 1'b0;
                end else if (win_end) begin
                    state_next  = ST_SETTLE;
                    slip_next   = slip_inc;
                    settle_next = '0;
                    run_next    = '0;
                end
            end
            ST_LOCKED: begin
                run_next    = run_step;
                win_next    = win_cnt + WIN_ONE;
                locked_next = 1'b1;
                if (win_end) begin
                    seen_next = 1'b0;
                    if (seen_run || run_hit) begin
                        miss_next = '0;
                    end else if (miss_inc == MISS_MAX) begin
                        state_next  = ST_SETTLE;
                        locked_next = 1'b0;
                        lost_next   = 1'b1;
                        slip_next   = slip_inc;
                        settle_next = '0;
                        run_next    = '0;
                        miss_next   = '0;
                        win_next    = '0;
                    end else begin
                        miss_next = miss_inc;
                    end
                end else if (run_hit) begin
                    seen_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_SETTLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_SETTLE;
            win_cnt    <= '0;
            run_cnt    <= '0;
            miss_cnt   <= '0;
            settle_cnt <= '0;
            seen_run   <= 1'b0;
            o_slip     <= 5'd0;
            o_locked   <= 1'b0;
            o_lost     <= 1'b0;
        end else begin
            state      <= state_next;
            win_cnt    <= win_next;
            run_cnt    <= run_next;
            miss_cnt   <= miss_next;
            settle_cnt <= settle_next;
            seen_run   <= seen_next;
            o_slip     <= slip_next;
            o_locked   <= locked_next;
            o_lost     <= lost_next;
        end
    end

endmodule

// File: tb/tb_hdmi_word_align.sv
// Self-checking bench for hdmi_word_align: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_hdmi_word_align;

    localparam int LGWINDOW = 8;
    localparam int RUNLEN   = 8;
    localparam int SETTLE_N = 4;
    localparam int MISSLIM  = 3;
    localparam int WINDOW   = 1 << LGWINDOW;

    localparam int PH_SETTLE = 0;
    localparam int PH_SEARCH = 1;
    localparam int PH_LOCKED = 2;

    localparam logic [9:0] TOK  = 10'h354;
    localparam logic [9:0] NONE = 10'h000;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [9:0] i_pixel;
    logic [4:0] o_slip;
    logic       o_locked;
    logic       o_lost;

    int errors = 0;
    int checks = 0;

    // Behavioural model: phase, clocks spent in phase, raw run length.
    int   m_phase = PH_SETTLE;
    int   m_age = 0;
    int   m_run = 0;
    int   m_missed = 0;
    bit   m_seen = 1'b0;
    int   m_slip = 0;
    bit   m_locked = 1'b0;
    bit   m_lost = 1'b0;
    bit   model_valid = 1'b0;

    hdmi_word_align #(
        .LGWINDOW(LGWINDOW),
        .RUNLEN  (RUNLEN),
        .SETTLE  (SETTLE_N),
        .MISSLIM (MISSLIM)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_pixel (i_pixel),
        .o_slip  (o_slip),
        .o_locked(o_locked),
        .o_lost  (o_lost)
    );

    // Free-running pixel clock.
    always #5 i_clk = ~i_clk;

    function automatic bit tokenOf(input logic [9:0] v);
        return (v == 10'h354) || (v == 10'h0ab) || (v == 10'h154) || (v == 10'h2ab);
    endfunction

    function automatic logic [9:0] randToken();
        logic [9:0] toks [4];
        toks[0] = 10'h354;
        toks[1] = 10'h0ab;
        toks[2] = 10'h154;
        toks[3] = 10'h2ab;
        return toks[$urandom_range(0, 3)];
    endfunction

    function automatic logic [9:0] randNonToken();
        logic [9:0] v;
        v = 10'($urandom);
        if (tokenOf(v)) v = v ^ 10'h001;
        return v;
    endfunction

    // Model update: work out the outputs each clock from the alignment rules.
    always @(posedge i_clk) begin
        bit tok;
        tok = tokenOf(i_pixel);
        if (i_reset) begin
            m_phase = PH_SETTLE; m_age = 0; m_run = 0; m_missed = 0;
            m_seen = 1'b0; m_slip = 0; m_locked = 1'b0; m_lost = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            m_lost = 1'b0;
            m_age = m_age + 1;
            if (m_phase == PH_SETTLE) begin
                m_locked = 1'b0;
                m_run = 0;
                if (m_age == SETTLE_N) begin
                    m_phase = PH_SEARCH;
                    m_age = 0;
                end
            end else if (m_phase == PH_SEARCH) begin
                m_locked = 1'b0;
                m_run = tok ? m_run + 1 : 0;
                if (m_run >= RUNLEN) begin
                    m_phase = PH_LOCKED; m_age = 0; m_missed = 0; m_seen = 1'b0;
                end else if (m_age == WINDOW) begin
                    m_slip = (m_slip + 1) % 10;
                    m_phase = PH_SETTLE;
                    m_age = 0;
                end
            end else begin
                m_locked = 1'b1;
                m_run = tok ? m_run + 1 : 0;
                if (m_run >= RUNLEN) m_seen = 1'b1;
                if (m_age % WINDOW == 0) begin
                    m_missed = m_seen ? 0 : m_missed + 1;
                    m_seen = 1'b0;
                    if (m_missed >= MISSLIM) begin
                        m_locked = 1'b0;
                        m_lost = 1'b1;
                        m_slip = (m_slip + 1) % 10;
                        m_phase = PH_SETTLE;
                        m_age = 0;
                        m_run = 0;
                    end
                end
            end
        end
    end

    // Every cycle once the model has seen a reset, the DUT must match it.
    always @(negedge i_clk) begin
        if (model_valid) begin
            checks = checks + 1;
            if (o_slip !== 5'(m_slip) || o_locked !== m_locked || o_lost !== m_lost) begin
                errors = errors + 1;
                $display("[TB] FAIL cycle_compare t=%0t: got slip=%0d locked=%b lost=%b, want slip=%0d locked=%b lost=%b",
                         $time, o_slip, o_locked, o_lost, m_slip, m_locked, m_lost);
            end
        end
    end

    // Drive inputs for n clocks; returns just after the last edge.
    task automatic applyStimulus(input logic rst, input logic [9:0] pix, input int n);
        repeat (n) begin
            i_reset = rst;
            i_pixel = pix;
            @(posedge i_clk);
            #1;
        end
    endtask

    // Check both the DUT and the model against hand-computed values.
    task automatic checkOutput(input string name, input int exp_slip, input bit exp_locked, input bit exp_lost);
        checks = checks + 1;
        if (o_slip !== 5'(exp_slip) || o_locked !== exp_locked || o_lost !== exp_lost) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got slip=%0d locked=%b lost=%b, want slip=%0d locked=%b lost=%b",
                     name, o_slip, o_locked, o_lost, exp_slip, exp_locked, exp_lost);
        end
        checks = checks + 1;
        if (m_slip != exp_slip || m_locked != exp_locked || m_lost != exp_lost) begin
            errors = errors + 1;
            $display("[TB] FAIL model_%s: model slip=%0d locked=%b lost=%b, want slip=%0d locked=%b lost=%b",
                     name, m_slip, m_locked, m_lost, exp_slip, exp_locked, exp_lost);
        end
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        i_reset = 1'b1;
        i_pixel = NONE;

        $display("[TB] constant token lock from reset");
        applyStimulus(1'b1, NONE, 2);
        checkOutput("reset", 0, 1'b0, 1'b0);
        applyStimulus(1'b0, TOK, 12);
        checkOutput("pre_lock_12", 0, 1'b0, 1'b0);
        applyStimulus(1'b0, TOK, 1);
        checkOutput("lock_13", 0, 1'b1, 1'b0);

        $display("[TB] run completes on the window's last clock");
        applyStimulus(1'b1, NONE, 1);
        applyStimulus(1'b0, NONE, 252);
        applyStimulus(1'b0, TOK, 8);
        checkOutput("edge_lock_priority", 0, 1'b0, 1'b0);
        applyStimulus(1'b0, TOK, 1);
        checkOutput("edge_lock_locked", 0, 1'b1, 1'b0);

        $display("[TB] slip stepping, lock at slip 3, loss, wrap");
        applyStimulus(1'b1, NONE, 1);
        applyStimulus(1'b0, NONE, 259);
        checkOutput("slip0_hold", 0, 1'b0, 1'b0);
        applyStimulus(1'b0, NONE, 1);
        checkOutput("slip_step1", 1, 1'b0, 1'b0);
        applyStimulus(1'b0, NONE, 259);
        checkOutput("slip1_hold", 1, 1'b0, 1'b0);
        applyStimulus(1'b0, NONE, 1);
        checkOutput("slip_step2", 2, 1'b0, 1'b0);
        applyStimulus(1'b0, NONE, 260);
        checkOutput("slip_step3", 3, 1'b0, 1'b0);
        applyStimulus(1'b0, TOK, 12);
        checkOutput("lock3_enter", 3, 1'b0, 1'b0);
        applyStimulus(1'b0, NONE, 1);
        checkOutput("lock3_locked", 3, 1'b1, 1'b0);
        applyStimulus(1'b0, NONE, 766);
        checkOutput("lock3_before_loss", 3, 1'b1, 1'b0);
        applyStimulus(1'b0, NONE, 1);
        checkOutput("loss_pulse", 4, 1'b0, 1'b1);
        applyStimulus(1'b0, NONE, 1);
        checkOutput("loss_pulse_end", 4, 1'b0, 1'b0);
        applyStimulus(1'b0, NONE, 1299);
        checkOutput("slip_at_9", 9, 1'b0, 1'b0);
        applyStimulus(1'b0, NONE, 259);
        checkOutput("slip9_hold", 9, 1'b0, 1'b0);
        applyStimulus(1'b0, NONE, 1);
        checkOutput("slip_wrap_0", 0, 1'b0, 1'b0);

        $display("[TB] broken runs do not lock");
        applyStimulus(1'b1, NONE, 1);
        applyStimulus(1'b0, NONE, 4);
        applyStimulus(1'b0, TOK, 7);
        applyStimulus(1'b0, NONE, 1);
        applyStimulus(1'b0, TOK, 7);
        checkOutput("run7_no_lock", 0, 1'b0, 1'b0);
        applyStimulus(1'b0, NONE, 1);
        applyStimulus(1'b0, TOK, 8);
        checkOutput("run8_enter", 0, 1'b0, 1'b0);
        applyStimulus(1'b0, TOK, 1);
        checkOutput("run8_locked", 0, 1'b1, 1'b0);

        $display("[TB] reset while locked at slip 5");
        applyStimulus(1'b1, NONE, 1);
        applyStimulus(1'b0, NONE, 1300);
        checkOutput("slip5_reached", 5, 1'b0, 1'b0);
        applyStimulus(1'b0, TOK, 13);
        checkOutput("slip5_locked", 5, 1'b1, 1'b0);
        applyStimulus(1'b1, TOK, 1);
        checkOutput("reset_while_locked", 0, 1'b0, 1'b0);
        applyStimulus(1'b0, TOK, 1);
        checkOutput("after_reset_release", 0, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int seg = 0; seg < 30; seg++) begin
            int mode;
            int len;
            mode = $urandom_range(0, 3);
            len  = $urandom_range(20, 900);
            if ($urandom_range(0, 11) == 0)
                applyStimulus(1'b1, randNonToken(), $urandom_range(1, 2));
            for (int c = 0; c < len; c++) begin
                logic [9:0] pix;
                case (mode)
                    0:       pix = randNonToken();
                    1:       pix = randToken();
                    2:       pix = ($urandom_range(0, 31) == 0) ? randNonToken() : randToken();
                    default: pix = ($urandom_range(0, 1) == 0) ? randNonToken() : randToken();
                endcase
                applyStimulus(1'b0, pix, 1);
            end
        end

        applyStimulus(1'b0, NONE, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdmi_word_align.md
HDMI_WORD_ALIGN -- requirements
Module: hdmiwordalign

Interface
REQ-001 SHALL provide parameter LGWINDOW, default 20, log2 of the search/monitor window length in pixel clocks.
REQ-002 SHALL provide parameter RUNLEN, default 8, the number of consecutive control tokens that proves alignment.
REQ-003 SHALL provide parameter SETTLE, default 4, the number of clocks ignored after any slip change; legal range 3..15.
REQ-004 SHALL provide parameter MISSLIM, default 3, the number of consecutive token-free windows that drops lock; legal range 1..15.
REQ-005 SHALL have port i_clk, input, 1 bit: pixel clock; the only clock.
REQ-006 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_pixel, input, 10 bits: aligned word returned by the downstream slip stage.
REQ-008 SHALL have port o_slip, output, 5 bits: slip amount driven to the slip stage, legal values 0..9.
REQ-009 SHALL have port o_locked, output, 1 bit: alignment confirmed.
REQ-010 SHALL have port o_lost, output, 1 bit: one-clock pulse when lock is dropped.

Function
REQ-011 SHALL treat i_pixel as a control token iff it equals 10'h354, 10'h0ab, 10'h154 or 10'h2ab.
REQ-012 SHALL implement exactly three states: SETTLE, SEARCH, LOCKED.
REQ-013 SHALL, in SETTLE, count SETTLE clocks, ignore i_pixel, and then enter SEARCH with the window counter and run counter cleared.
REQ-014 SHALL maintain a run counter that increments on each token, clears on any non-token, and saturates at RUNLEN.
REQ-015 SHALL, in SEARCH, enter LOCKED on the clock the run counter reaches RUNLEN, with o_locked = 1 from the following clock.
REQ-016 SHALL, in SEARCH, when the window counter reaches 2^LGWINDOW-1 without a run, advance o_slip by 1 and enter SETTLE.
REQ-017 SHALL wrap o_slip from 9 to 0, and SHALL never drive o_slip above 9.
REQ-018 SHALL, if a run completes on the same clock the window terminates, give lock priority and leave o_slip unchanged.
REQ-019 SHALL, in LOCKED, restart the window counter at every window boundary and latch a seen-run flag whenever the run counter reaches RUNLEN.
REQ-020 SHALL, at each LOCKED window boundary with no run seen, increment the miss counter; a window boundary with a run seen SHALL clear it.
REQ-021 SHALL, when the miss counter reaches MISSLIM, on that clock: clear o_locked, pulse o_lost, advance o_slip per REQ-017, and enter SETTLE.
REQ-022 SHALL hold o_slip constant in every state except on the transitions given in REQ-016 and REQ-021.
REQ-023 SHALL size the window counter at LGWINDOW bits and let it wrap naturally.
REQ-024 SHALL register all outputs, with no combinational path from i_pixel to any output.

Reset
REQ-025 SHALL, when i_reset is asserted, on the next clock set state=SETTLE, o_slip=0, o_locked=0, o_lost=0, and clear the window, run, miss and settle counters and the seen-run flag.
REQ-026 SHALL treat i_reset asserted mid-operation (including while LOCKED) identically to reset at power-up, without pulsing o_lost.
REQ-027 SHALL give i_reset priority over every other transition on the same clock.

Verification (bench uses LGWINDOW=8, RUNLEN=8, SETTLE=4, MISSLIM=3)
REQ-028 SHALL verify: reset, then constant 10'h354 -> o_locked=1 on clock 4+8+1 after reset release, with o_slip=0.
REQ-029 SHALL verify: reset, then no tokens for 3 windows -> o_slip steps 0->1->2, with each step 4+256 clocks apart and o_locked=0 throughout.
REQ-030 SHALL verify: tokens withheld until o_slip=9, then window expiry -> o_slip wraps to 0, never reaching 10.
REQ-031 SHALL verify: run of 7 tokens, one non-token, then 7 tokens -> no lock; a subsequent run of 8 -> lock.
REQ-032 SHALL verify: locked at slip=3, tokens removed -> o_lost pulses once, exactly 3 windows later; o_slip=4 and o_locked=0 on the same clock.
REQ-033 SHALL verify: i_reset asserted while LOCKED at slip=5 -> next clock o_slip=0, o_locked=0, and o_lost stays 0.
